sequential_logical_right_shift: RTL and testbench
=================================================

// Module: sequential_logical_right_shift
// PURPOSE
//  Multi-cycle 16-bit logical right shifter. It is the right-direction counterpart of the
//  ALU's combinational logical left shift: it shifts A right by B, one bit per clock.
//  It flags lost 1-bits as underflow, mirroring the left shifter's overflow flag.
//  Sits beside the ALU shift units and uses a start/busy/done handshake toward the controller.
// PARAMETERS
//  WIDTH  16  data width of A, B and out
//  CNT_W  5   shift counter width; must satisfy 2**CNT_W > WIDTH
// PORTS
//  clk        in   1      single clock; all state changes on the rising edge
//  rst        in   1      synchronous, active-high reset
//  start      in   1      request; accepted only when busy==0
//  A          in   WIDTH  operand to shift; sampled on the accepting edge
//  B          in   WIDTH  unsigned shift amount; sampled on the accepting edge
//  out        out  WIDTH  result; updates only at completion, holds until the next completion
//  underflow  out  1      1 if any 1-bit was shifted out; updates together with out
//  busy       out  1      high from the accepting edge until the completing edge
//  done       out  1      one-cycle pulse on the completing edge
// BEHAVIOUR
//  Reset: state=IDLE, out=0, underflow=0, busy=0, done=0, internal reg/count/sticky=0.
//   Reset taken mid-operation aborts the operation; no done pulse follows.
//  Amount clamp: n = (B >= WIDTH) ? WIDTH : B[CNT_W-1:0]. Shifting by >= WIDTH yields 0.
//  States:
//   IDLE : done=0 unless just completed. If start: sh<=A, cnt<=n, sticky<=0, busy<=1, go SHIFT.
//   SHIFT: if cnt!=0: sh<=sh>>1 (zero-fill MSB), sticky<=sticky|sh[0], cnt<=cnt-1.
//          if cnt==0: out<=sh, underflow<=sticky, done<=1, busy<=0, go IDLE.
//  Latency: accepting edge k -> done high after edge k+n+1.
//   B=0 gives 1 cycle; B>=16 gives 17 cycles.
//  done is registered, lasts exactly one cycle, and is cleared on the following edge.
//  start while busy==1 is ignored (no queueing); A and B may change freely while busy.
//  start high in the same cycle done is high is accepted (back-to-back operation).
//  out and underflow are stable whenever busy==1; they show the previous result.
//  Pure logical shift: no sign extension, no rotate; B upper bits beyond the clamp are don't-care.
//  No combinational path from inputs to outputs.
// STRUCTURE
//  Shared defines header: WIDTH default and the state encodings
//   (IDLE=1'b0, SHIFT=1'b1), shared with the left shifter.
//  No sub-module: one state register, one data register, one down-counter, one sticky bit.
// TESTING
//  A=2, B=1, start 1 cycle -> done after 2 edges; out=16'h0001, underflow=0.
//  A=2, B=2 -> out=16'h0000, underflow=1 (bit 1 lost), latency 3.
//  A=16'h8000, B=15 -> out=16'h0001, underflow=0, busy high exactly 16 cycles.
//  A=16'hABCD, B=0 -> out=16'hABCD, underflow=0, done 1 cycle after start;
//   A=16'hFFFF, B=20 -> out=0, underflow=1, latency 17.
//  Sweep A=2, B=0..15 back-to-back (start asserted during done) -> out = 2>>B,
//   underflow=1 iff B>=2, no lost starts.
//  Start A=16'hFFFF, B=8; re-pulse start with A=1 while busy -> ignored, out=16'h00FF.
//   Next op asserts rst at busy cycle 3 -> all outputs 0 on the next edge, no done pulse.

Source files
------------

// File: rtl/sequential_logical_right_shift_pkg.sv
// rtl/sequential_logical_right_shift_pkg.sv - shared shifter widths and state encoding
package sequential_logical_right_shift_pkg;

  localparam int SLRS_WIDTH = 16;
  localparam int SLRS_CNT_W = 5;

  // Encoding is shared with the left shifter; keep the values fixed.
  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/sequential_logical_right_shift.sv
// rtl/sequential_logical_right_shift.sv - multi-cycle logical right shifter, one bit per clock
module sequential_logical_right_shift
  import sequential_logical_right_shift_pkg::*;
#(
  parameter int WIDTH = SLRS_WIDTH,
  parameter int CNT_W = SLRS_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] out,
  output logic             underflow,
  output logic             busy,
  output logic             done
);

  localparam logic [WIDTH-1:0] WIDTH_V   = WIDTH[WIDTH-1:0];
  localparam logic [CNT_W-1:0] WIDTH_CNT = CNT_W'(WIDTH);

  state_t           state, state_n;
  logic [WIDTH-1:0] sh, sh_n, out_n;
  logic [CNT_W-1:0] cnt, cnt_n, amt;
  logic             sticky, sticky_n, uf_n, busy_n, done_n;

  // Anything at or beyond WIDTH empties the register, so clamp to WIDTH steps.
  assign amt = (B >= WIDTH_V) ? WIDTH_CNT : B[CNT_W-1:0];

  always_comb begin
    state_n  = state;
    sh_n     = sh;
    cnt_n    = cnt;
    sticky_n = sticky;
    out_n    = out;
    uf_n     = underflow;
    busy_n   = busy;
    done_n   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          sh_n     = A;
          cnt_n    = amt;
          sticky_n = 1'b0;
          busy_n   = 1'b1;
          state_n  = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt != '0) begin
          sh_n     = sh >> 1;
          sticky_n = sticky | sh[0];
          cnt_n    = cnt - CNT_W'(1);
        end else begin
          out_n   = sh;
          uf_n    = sticky;
          done_n  = 1'b1;
          busy_n  = 1'b0;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      sh        <= '0;
      cnt       <= '0;
      sticky    <= 1'b0;
      out       <= '0;
      underflow <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_n;
      sh        <= sh_n;
      cnt       <= cnt_n;
      sticky    <= sticky_n;
      out       <= out_n;
      underflow <= uf_n;
      busy      <= busy_n;
      done      <= done_n;
    end
  end

endmodule

// File: tb/tb_sequential_logical_right_shift.sv
// tb/tb_sequential_logical_right_shift.sv - randomized self-checking bench for the right shifter
module tb_sequential_logical_right_shift;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] A = '0;
  logic [15:0] B = '0;
  logic [15:0] out;
  logic        underflow, busy, done;

  int errors = 0;
  int checks = 0;

  sequential_logical_right_shift dut (
    .clk(clk), .rst(rst), .start(start), .A(A), .B(B),
    .out(out), .underflow(underflow), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic int ref_amt(input logic [15:0] b);
    return (b >= 16) ? 16 : int'(b);
  endfunction

  function automatic logic [15:0] ref_out(input logic [15:0] a, input logic [15:0] b);
    logic [31:0] wide;
    wide = {16'h0, a};
    return 16'(wide >> ref_amt(b));
  endfunction

  function automatic logic ref_uf(input logic [15:0] a, input logic [15:0] b);
    logic [31:0] mask;
    mask = (32'd1 << ref_amt(b)) - 32'd1;
    return (({16'h0, a} & mask) != 32'd0);
  endfunction

  // Called at the drive point (#1 after a rising edge); returns there after the accepting edge.
  task automatic launch(input logic [15:0] a, input logic [15:0] b);
    A = a; B = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    A = 16'($urandom); B = 16'($urandom);
  endtask

  // Counts edges after the accepting edge until done is seen; also notes whether out moved while busy.
  task automatic wait_done(output int lat, output bit ok, output bit stable, output int busy_cnt);
    logic [15:0] held;
    logic        held_uf;
    held = out; held_uf = underflow;
    lat = 0; ok = 1'b0; stable = 1'b1; busy_cnt = busy ? 1 : 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      lat++;
      if (done) begin ok = 1'b1; break; end
      if (busy) busy_cnt++;
      if (out !== held || underflow !== held_uf) stable = 1'b0;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({out, underflow, busy, done} !== 19'h0) begin
      errors++;
      $display("FAIL reset_state: out=%h uf=%b busy=%b done=%b, required all 0", out, underflow, busy, done);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_directed;
    logic [15:0] ta [5] = '{16'h0002, 16'h0002, 16'h8000, 16'hABCD, 16'hFFFF};
    logic [15:0] tb [5] = '{16'd1, 16'd2, 16'd15, 16'd0, 16'd20};
    int lat, bc; bit ok, st;
    for (int i = 0; i < 5; i++) begin
      launch(ta[i], tb[i]);
      wait_done(lat, ok, st, bc);
      checks++;
      if (!ok || out !== ref_out(ta[i], tb[i]) || underflow !== ref_uf(ta[i], tb[i])
          || lat != ref_amt(tb[i]) + 1 || busy !== 1'b0) begin
        errors++;
        $display("FAIL directed_%0d: out=%h uf=%b lat=%0d busy=%b done_seen=%b, required out=%h uf=%b lat=%0d busy=0",
                 i, out, underflow, lat, busy, ok, ref_out(ta[i], tb[i]), ref_uf(ta[i], tb[i]), ref_amt(tb[i]) + 1);
      end
      if (tb[i] == 16'd15) begin
        checks++;
        if (bc != 16) begin
          errors++;
          $display("FAIL busy_width_b15: busy cycles=%0d, required 16", bc);
        end
      end
      @(posedge clk); #1;
      checks++;
      if (done !== 1'b0) begin
        errors++;
        $display("FAIL done_one_cycle_%0d: done=%b, required 0", i, done);
      end
    end
  endtask

  task automatic test_random;
    logic [15:0] a, b;
    int lat, bc; bit ok, st;
    for (int i = 0; i < 30; i++) begin
      a = 16'($urandom);
      b = (i % 4 == 3) ? 16'($urandom) : 16'($urandom_range(0, 17));
      launch(a, b);
      wait_done(lat, ok, st, bc);
      checks++;
      if (!ok || out !== ref_out(a, b) || underflow !== ref_uf(a, b) || lat != ref_amt(b) + 1 || !st) begin
        errors++;
        $display("FAIL random_%0d A=%h B=%h: out=%h uf=%b lat=%0d stable=%b, required out=%h uf=%b lat=%0d stable=1",
                 i, a, b, out, underflow, lat, st, ref_out(a, b), ref_uf(a, b), ref_amt(b) + 1);
      end
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #0;
      if ($time % 10 != 6) begin @(posedge clk); #1; end
    end
  endtask

  task automatic test_back_to_back;
    int lat, bc; bit ok, st;
    launch(16'h0002, 16'd0);
    for (int b = 0; b < 16; b++) begin
      wait_done(lat, ok, st, bc);
      checks++;
      if (!ok || out !== ref_out(16'h0002, 16'(b)) || underflow !== (b >= 2) || lat != b + 1) begin
        errors++;
        $display("FAIL sweep_b%0d: out=%h uf=%b lat=%0d, required out=%h uf=%b lat=%0d",
                 b, out, underflow, lat, ref_out(16'h0002, 16'(b)), (b >= 2), b + 1);
      end
      if (b < 15) begin
        launch(16'h0002, 16'(b + 1));
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
          errors++;
          $display("FAIL sweep_accept_b%0d: busy=%b done=%b, required busy=1 done=0", b + 1, busy, done);
        end
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_ignore_start;
    int lat, bc; bit ok, st;
    launch(16'hFFFF, 16'd8);
    @(posedge clk); #1;
    A = 16'h0001; B = 16'h0000; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(lat, ok, st, bc);
    checks++;
    if (!ok || out !== 16'h00FF || underflow !== 1'b1 || lat + 2 != 9) begin
      errors++;
      $display("FAIL ignore_start: out=%h uf=%b lat=%0d, required out=00ff uf=1 lat=9", out, underflow, lat + 2);
    end
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL no_queue: busy=%b done=%b, required busy=0 done=0", busy, done);
    end
  endtask

  task automatic test_mid_reset;
    bit seen;
    launch(16'h1234, 16'd10);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if ({out, underflow, busy, done} !== 19'h0) begin
      errors++;
      $display("FAIL mid_reset: out=%h uf=%b busy=%b done=%b, required all 0", out, underflow, busy, done);
    end
    seen = 1'b0;
    repeat (15) begin
      @(posedge clk); #1;
      if (done || busy) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL abort_no_done: done or busy seen after reset, required neither");
    end
  endtask

  initial begin
    test_reset;
    test_directed;
    test_random;
    test_back_to_back;
    test_ignore_start;
    test_mid_reset;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
